wishbone_dev_pipelined: RTL and testbench
=========================================

// Module: wishbone_dev_pipelined
//
// PURPOSE
// Wishbone B4 pipelined-mode device adapter. Generalises the single-cycle classic device
// to parametrised address/data/byte-select widths and up to DEPTH requests in flight.
// Buffers requests in an internal FIFO. Returns in-order responses as one-cycle ack_o/err_o
// pulses. Handles a master abort (cyc_i dropped mid-burst) cleanly.
// Sits between a bus interconnect and a simple register/memory device using a valid/ready
// request channel and a valid-only response channel.
//
// PARAMETERS
// ADR_WIDTH  8              address width
// DAT_WIDTH  32             data width; multiple of 8
// SEL_WIDTH  DAT_WIDTH/8    byte-select width
// DEPTH      2              max requests in flight (FIFO + awaiting response); power of 2, >=2
//
// PORTS
// clk_i      in   1          clock; all logic on rising edge
// rst_ni     in   1          reset, asynchronous assert, active-low
// cyc_i      in   1          bus cycle active
// stb_i      in   1          request strobe
// we_i       in   1          1 = write, 0 = read
// adr_i      in   ADR_WIDTH  address
// dat_i      in   DAT_WIDTH  write data
// sel_i      in   SEL_WIDTH  byte selects
// dat_o      out  DAT_WIDTH  read data, valid with ack_o
// ack_o      out  1          normal completion, one-cycle pulse per request
// err_o      out  1          error completion, one-cycle pulse per request
// stall_o    out  1          request not accepted this cycle
// req_valid  out  1          request to device valid
// req_ready  in   1          device accepts request
// req_we     out  1          request type
// req_adr    out  ADR_WIDTH  request address
// req_wdata  out  DAT_WIDTH  request write data
// req_sel    out  SEL_WIDTH  request byte selects
// rsp_valid  in   1          device response, exactly one per accepted request, in order
// rsp_data   in   DAT_WIDTH  response read data
// rsp_err    in   1          response is an error
//
// BEHAVIOUR
// - Reset (rst_ni=0, async):
//   - FIFO empty; counters pend=drop=0.
//   - dat_o=0, ack_o=0, err_o=0, stall_o=0, req_valid=0.
//   - Reset mid-transaction discards everything; the device is reset alongside.
// - Accept: at a rising edge with cyc_i&&stb_i&&!stall_o, push {we,adr,dat,sel}; pend+=1.
// - stall_o = (pend+drop >= DEPTH). Combinational from registers only, never from stb_i.
// - req_valid = cyc_i && FIFO non-empty; req_* = FIFO head.
//   - Pop on req_valid&&req_ready.
//   - Same-edge push and pop on a full FIFO is legal.
// - Response (rsp_valid at an edge):
//   - If drop>0: drop-=1; no ack_o/err_o, dat_o unchanged.
//   - Else: next cycle ack_o=!rsp_err, err_o=rsp_err; dat_o<=rsp_data; pend-=1.
//   - ack_o and err_o are never both high. Each lasts exactly one cycle.
//   - rsp_valid with nothing issued is ignored.
// - Simultaneous accept and response: pend unchanged.
// - Abort (cyc_i=0 at an edge):
//   - FIFO flushed; its unissued entries are removed from pend.
//   - Issued-but-unanswered count moves to drop; pend=0.
//   - Pending ack_o/err_o registers cleared.
//   - New cycles may start next edge; their responses follow the dropped ones.
// - Latency: device with req_ready=1 and same-cycle rsp_valid gives stb_i accepted at
//   edge 0 -> req_valid cycle 1 -> ack_o high in cycle 2.
// - Throughput: one request per cycle with DEPTH>=2.
// - Counters are $clog2(DEPTH+1) bits and never wrap; pend+drop <= DEPTH always.
//
// TESTING
// 1. Single read adr=0x10, device returns 0xDEADBEEF same cycle -> ack_o one pulse in
//    cycle 2, dat_o=0xDEADBEEF, stall_o never high.
// 2. 8 back-to-back writes, DEPTH=2, req_ready=1, rsp same cycle -> no stall_o, 8 ack_o
//    pulses on consecutive cycles, req_* order matches.
// 3. req_ready=0 for 5 cycles, 3 strobes -> stall_o high after 2 accepted; 3rd accepted
//    after ready returns; 3 acks in order.
// 4. rsp_err=1 on 2nd of 3 reads -> ack_o, err_o, ack_o pulses; never both high.
// 5. 2 issued, cyc_i dropped before responses; new read with rsp 0x55 -> first 2 responses
//    swallowed, single ack_o with dat_o=0x55.
// 6. rst_ni low mid-burst with pend=2 -> all outputs 0 immediately; stall_o=0; next read
//    completes normally.

Source files
------------

// File: rtl/wishbone_dev_pipelined_if.sv
// Wishbone B4 pipelined bus bundle between an interconnect (master) and the device adapter (slave).
// Signal names keep the device's point of view (_i driven by the master, _o by the slave).
interface wishbone_dev_pipelined_if #(
   parameter int ADR_WIDTH = 8,
   parameter int DAT_WIDTH = 32,
   parameter int SEL_WIDTH = DAT_WIDTH / 8
);
   logic                 cyc_i;
   logic                 stb_i;
   logic                 we_i;
   logic [ADR_WIDTH-1:0] adr_i;
   logic [DAT_WIDTH-1:0] dat_i;
   logic [SEL_WIDTH-1:0] sel_i;
   logic [DAT_WIDTH-1:0] dat_o;
   logic                 ack_o;
   logic                 err_o;
   logic                 stall_o;

   modport master (
      output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
      input  dat_o, ack_o, err_o, stall_o
   );

   modport slave (
      input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
      output dat_o, ack_o, err_o, stall_o
   );
endinterface

// File: rtl/wishbone_dev_pipelined.sv
// Wishbone B4 pipelined device adapter: queues up to DEPTH requests towards a valid/ready device
// port and returns in-order one-cycle ack/err pulses, swallowing responses left over from an abort.
module wishbone_dev_pipelined #(
   parameter int ADR_WIDTH = 8,
   parameter int DAT_WIDTH = 32,
   parameter int SEL_WIDTH = DAT_WIDTH / 8,
   parameter int DEPTH     = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   wishbone_dev_pipelined_if.slave wb,
   output logic                    req_valid,
   input  logic                    req_ready,
   output logic                    req_we,
   output logic [ADR_WIDTH-1:0]    req_adr,
   output logic [DAT_WIDTH-1:0]    req_wdata,
   output logic [SEL_WIDTH-1:0]    req_sel,
   input  logic                    rsp_valid,
   input  logic [DAT_WIDTH-1:0]    rsp_data,
   input  logic                    rsp_err
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam int EW = 1 + ADR_WIDTH + DAT_WIDTH + SEL_WIDTH;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   logic [EW-1:0]        fifo_mem [DEPTH];
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [CW-1:0]        fifo_cnt;
   logic [CW-1:0]        pend;
   logic [CW-1:0]        drop;
   logic [CW-1:0]        issued;
   logic [CW:0]          inflight;
   logic                 stall;
   logic                 push;
   logic                 pop;
   logic                 rsp_drop;
   logic                 rsp_take;
   logic                 ack_q;
   logic                 err_q;
   logic [DAT_WIDTH-1:0] dat_q;

   assign inflight  = {1'b0, pend} + {1'b0, drop};
   assign stall     = inflight >= DEPTH_W;
   assign push      = wb.cyc_i && wb.stb_i && !stall;
   assign req_valid = wb.cyc_i && (fifo_cnt != '0);
   assign pop       = req_valid && req_ready;
   assign {req_we, req_adr, req_wdata, req_sel} = fifo_mem[rd_ptr];

   // A request popped this cycle counts as issued, so a device answering combinationally is matched.
   assign issued   = pend - fifo_cnt;
   assign rsp_drop = rsp_valid && (drop != '0);
   assign rsp_take = rsp_valid && (drop == '0) && ((issued != '0) || pop);

   assign wb.stall_o = stall;
   assign wb.ack_o   = ack_q;
   assign wb.err_o   = err_q;
   assign wb.dat_o   = dat_q;

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {wb.we_i, wb.adr_i, wb.dat_i, wb.sel_i};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         pend     <= '0;
         drop     <= '0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         dat_q    <= '0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         if (!wb.cyc_i) begin
            // Abort: unissued entries vanish, anything the device still owes us becomes a drop.
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            pend     <= '0;
            drop     <= drop - CW'(rsp_drop) + issued - CW'(rsp_take);
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
            pend     <= pend + CW'(push) - CW'(rsp_take);
            drop     <= drop - CW'(rsp_drop);
            if (rsp_take) begin
               ack_q <= !rsp_err;
               err_q <= rsp_err;
               dat_q <= rsp_data;
            end
         end
      end
   end
endmodule

// File: tb/tb_wishbone_dev_pipelined.sv
// Self-checking bench for wishbone_dev_pipelined: directed scenarios plus random traffic, compared
// against a request/response queue model of the adapter and a simple device model.
module tb_wishbone_dev_pipelined;
   localparam int AW    = 8;
   localparam int DW    = 32;
   localparam int SW    = 4;
   localparam int DEPTH = 2;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
      logic [SW-1:0] sel;
   } req_t;

   typedef struct packed {
      logic dropped;
      req_t r;
   } out_t;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_adr;
   logic [DW-1:0] req_wdata;
   logic [SW-1:0] req_sel;
   logic          rsp_valid, rsp_err;
   logic [DW-1:0] rsp_data;

   logic          dev_auto, fix_en, man_valid, man_err;
   logic [DW-1:0] fix_data, man_data;

   req_t          wait_q[$];
   out_t          issued_q[$];
   logic          exp_ack, exp_err;
   logic [DW-1:0] exp_dat;
   int            n_cmp, n_fail, n_ack, n_errp;
   bit            dut_accept;

   always #5 clk_i = ~clk_i;

   wishbone_dev_pipelined_if #(.ADR_WIDTH(AW), .DAT_WIDTH(DW), .SEL_WIDTH(SW)) wb ();

   wishbone_dev_pipelined #(.ADR_WIDTH(AW), .DAT_WIDTH(DW), .SEL_WIDTH(SW), .DEPTH(DEPTH)) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .wb        (wb.slave),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_adr   (req_adr),
      .req_wdata (req_wdata),
      .req_sel   (req_sel),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err)
   );

   function automatic logic [DW-1:0] devRead(input logic [AW-1:0] a);
      return {a, ~a, a ^ 8'h5A, 8'hC3};
   endfunction

   function automatic logic devErr(input logic [AW-1:0] a);
      return a[7:4] == 4'hF;
   endfunction

   // Device: auto mode answers in the same cycle it accepts; manual mode is driven step by step.
   assign rsp_valid = dev_auto ? (req_valid && req_ready) : man_valid;
   assign rsp_data  = dev_auto ? (fix_en ? fix_data : (req_we ? '0 : devRead(req_adr))) : man_data;
   assign rsp_err   = dev_auto ? devErr(req_adr) : man_err;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic setReq(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [SW-1:0] sel);
      wb.stb_i = 1'b1;
      wb.we_i  = we;
      wb.adr_i = adr;
      wb.dat_i = dat;
      wb.sel_i = sel;
   endtask

   task automatic modelReset();
      wait_q.delete();
      issued_q.delete();
      exp_ack = 1'b0;
      exp_err = 1'b0;
      exp_dat = '0;
   endtask

   // One clock cycle: called at a falling edge with inputs already set.
   task automatic applyStimulus();
      bit   exp_stall, accept, issue, rsp, perr;
      req_t cur;
      out_t o;
      #1;
      exp_stall = (wait_q.size() + issued_q.size()) >= DEPTH;
      checkOutput("stall_o", 64'(wb.stall_o), 64'(exp_stall));
      checkOutput("req_valid", 64'(req_valid), 64'(wb.cyc_i && wait_q.size() > 0));
      if (wb.cyc_i && wait_q.size() > 0) begin
         checkOutput("req_head", 64'({req_we, req_adr, req_wdata, req_sel}), 64'(wait_q[0]));
      end
      dut_accept = wb.cyc_i && wb.stb_i && !wb.stall_o;
      cur    = '{we: wb.we_i, adr: wb.adr_i, dat: wb.dat_i, sel: wb.sel_i};
      accept = wb.cyc_i && wb.stb_i && !exp_stall;
      issue  = wb.cyc_i && req_ready && wait_q.size() > 0;
      rsp    = dev_auto ? issue : man_valid;
      exp_ack = 1'b0;
      exp_err = 1'b0;
      if (issue) begin
         issued_q.push_back('{dropped: 1'b0, r: wait_q.pop_front()});
      end
      if (accept) begin
         wait_q.push_back(cur);
      end
      if (rsp && issued_q.size() > 0) begin
         o = issued_q.pop_front();
         if (!o.dropped && wb.cyc_i) begin
            perr    = dev_auto ? devErr(o.r.adr) : man_err;
            exp_err = perr;
            exp_ack = !perr;
            exp_dat = dev_auto ? (fix_en ? fix_data : (o.r.we ? '0 : devRead(o.r.adr))) : man_data;
         end
      end
      if (!wb.cyc_i) begin
         wait_q.delete();
         foreach (issued_q[i]) issued_q[i].dropped = 1'b1;
      end
      @(posedge clk_i);
      @(negedge clk_i);
      checkOutput("ack_o", 64'(wb.ack_o), 64'(exp_ack));
      checkOutput("err_o", 64'(wb.err_o), 64'(exp_err));
      checkOutput("dat_o", 64'(wb.dat_o), 64'(exp_dat));
      if (wb.ack_o) n_ack++;
      if (wb.err_o) n_errp++;
   endtask

   initial begin
      int a0, e0;
      n_cmp = 0; n_fail = 0; n_ack = 0; n_errp = 0;
      rst_ni = 1'b0;
      wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
      wb.adr_i = '0; wb.dat_i = '0; wb.sel_i = '0;
      req_ready = 1'b1; dev_auto = 1'b1; fix_en = 1'b0; fix_data = '0;
      man_valid = 1'b0; man_err = 1'b0; man_data = '0;
      modelReset();
      #1;
      checkOutput("rst_ack", 64'(wb.ack_o), 64'(0));
      checkOutput("rst_err", 64'(wb.err_o), 64'(0));
      checkOutput("rst_stall", 64'(wb.stall_o), 64'(0));
      checkOutput("rst_dat", 64'(wb.dat_o), 64'(0));
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;

      $display("[TB] single read, same-cycle device response");
      fix_en = 1'b1; fix_data = 32'hDEADBEEF; wb.cyc_i = 1'b1;
      setReq(1'b0, 8'h10, '0, 4'hF);
      applyStimulus();
      wb.stb_i = 1'b0;
      applyStimulus();
      checkOutput("t1_ack", 64'(wb.ack_o), 64'(1));
      checkOutput("t1_dat", 64'(wb.dat_o), 64'(32'hDEADBEEF));
      applyStimulus();
      fix_en = 1'b0;

      $display("[TB] eight back-to-back writes");
      a0 = n_ack;
      for (int i = 0; i < 8; i++) begin
         setReq(1'b1, 8'(8'h40 + i), $urandom, 4'(i + 1));
         applyStimulus();
      end
      wb.stb_i = 1'b0;
      repeat (2) applyStimulus();
      checkOutput("t2_acks", 64'(n_ack - a0), 64'(8));

      $display("[TB] device not ready, stall after two");
      a0 = n_ack; req_ready = 1'b0;
      setReq(1'b0, 8'h21, '0, 4'hF); applyStimulus();
      setReq(1'b0, 8'h22, '0, 4'hF); applyStimulus();
      checkOutput("t3_stall", 64'(wb.stall_o), 64'(1));
      setReq(1'b0, 8'h23, '0, 4'hF);
      repeat (3) applyStimulus();
      req_ready = 1'b1;
      dut_accept = 1'b0;
      for (int k = 0; k < 10 && !dut_accept; k++) applyStimulus();
      checkOutput("t3_third_accepted", 64'(dut_accept), 64'(1));
      wb.stb_i = 1'b0;
      repeat (3) applyStimulus();
      checkOutput("t3_acks", 64'(n_ack - a0), 64'(3));

      $display("[TB] error on middle read");
      a0 = n_ack; e0 = n_errp;
      setReq(1'b0, 8'h20, '0, 4'hF); applyStimulus();
      setReq(1'b0, 8'hF4, '0, 4'hF); applyStimulus();
      setReq(1'b0, 8'h24, '0, 4'hF); applyStimulus();
      wb.stb_i = 1'b0;
      repeat (2) applyStimulus();
      checkOutput("t4_acks", 64'(n_ack - a0), 64'(2));
      checkOutput("t4_errs", 64'(n_errp - e0), 64'(1));

      $display("[TB] abort with two issued, then new read");
      dev_auto = 1'b0; man_valid = 1'b0;
      setReq(1'b0, 8'h50, '0, 4'hF); applyStimulus();
      setReq(1'b0, 8'h54, '0, 4'hF); applyStimulus();
      wb.stb_i = 1'b0; applyStimulus();
      a0 = n_ack;
      wb.cyc_i = 1'b0; applyStimulus();
      checkOutput("t5_stall_after_abort", 64'(wb.stall_o), 64'(1));
      wb.cyc_i = 1'b1; setReq(1'b0, 8'h58, '0, 4'hF);
      man_valid = 1'b1; man_data = 32'hAA; applyStimulus();
      man_data = 32'hBB; applyStimulus();
      wb.stb_i = 1'b0; man_valid = 1'b0; applyStimulus();
      man_valid = 1'b1; man_data = 32'h55; applyStimulus();
      man_valid = 1'b0;
      checkOutput("t5_dat", 64'(wb.dat_o), 64'(32'h55));
      applyStimulus();
      checkOutput("t5_acks", 64'(n_ack - a0), 64'(1));

      $display("[TB] asynchronous reset mid-burst");
      dev_auto = 1'b1; req_ready = 1'b0;
      setReq(1'b0, 8'h60, '0, 4'hF); applyStimulus();
      setReq(1'b0, 8'h64, '0, 4'hF); applyStimulus();
      wb.stb_i = 1'b0;
      #2 rst_ni = 1'b0;
      #1;
      checkOutput("t6_stall", 64'(wb.stall_o), 64'(0));
      checkOutput("t6_req_valid", 64'(req_valid), 64'(0));
      checkOutput("t6_ack", 64'(wb.ack_o), 64'(0));
      checkOutput("t6_err", 64'(wb.err_o), 64'(0));
      checkOutput("t6_dat", 64'(wb.dat_o), 64'(0));
      modelReset();
      @(negedge clk_i);
      rst_ni = 1'b1; req_ready = 1'b1;
      setReq(1'b0, 8'h68, '0, 4'hF); applyStimulus();
      wb.stb_i = 1'b0; applyStimulus();
      checkOutput("t6_read_dat", 64'(wb.dat_o), 64'(devRead(8'h68)));
      applyStimulus();

      $display("[TB] random traffic, same-cycle device");
      for (int i = 0; i < 250; i++) begin
         wb.cyc_i  = ($urandom_range(0, 9) != 0);
         wb.stb_i  = ($urandom_range(0, 9) < 7);
         wb.we_i   = $urandom_range(0, 1) == 1;
         wb.adr_i  = 8'($urandom);
         wb.dat_i  = $urandom;
         wb.sel_i  = 4'($urandom);
         req_ready = ($urandom_range(0, 9) < 6);
         applyStimulus();
      end

      $display("[TB] random traffic, delayed device");
      dev_auto = 1'b0;
      for (int i = 0; i < 250; i++) begin
         wb.cyc_i  = ($urandom_range(0, 9) != 0);
         wb.stb_i  = ($urandom_range(0, 9) < 7);
         wb.we_i   = $urandom_range(0, 1) == 1;
         wb.adr_i  = 8'($urandom);
         wb.dat_i  = $urandom;
         wb.sel_i  = 4'($urandom);
         req_ready = ($urandom_range(0, 9) < 6);
         man_valid = ($urandom_range(0, 2) == 0) && (issued_q.size() > 0);
         man_data  = $urandom;
         man_err   = ($urandom_range(0, 4) == 0);
         applyStimulus();
      end
      wb.cyc_i = 1'b1; wb.stb_i = 1'b0; req_ready = 1'b1;
      for (int k = 0; k < 40 && (wait_q.size() + issued_q.size()) > 0; k++) begin
         man_valid = issued_q.size() > 0;
         man_data  = $urandom;
         man_err   = 1'b0;
         applyStimulus();
      end
      man_valid = 1'b0;
      applyStimulus();
      checkOutput("drain_stall", 64'(wb.stall_o), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
